// File: rtl/main_slave_mem.sv
// Single-port word-addressed memory target for the arbiter's slave channel.
// One request in flight at a time, with a configurable ack delay and read latency.
module main_slave_mem #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 256,
    parameter int ACK_DELAY    = 0,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    input  logic              cmd_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ack_o,
    output logic              resp_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DLY_LAST = 4'((ACK_DELAY > 0) ? ACK_DELAY - 1 : 0);
    localparam logic [3:0] LAT_LAST = 4'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("main_slave_mem: DEPTH must be a power of two and at least 2");
    end
    if ((READ_LATENCY < 1) || (READ_LATENCY > 15)) begin : g_chk_lat
        $error("main_slave_mem: READ_LATENCY must be in 1..15");
    end
    if ((ACK_DELAY < 0) || (ACK_DELAY > 15)) begin : g_chk_dly
        $error("main_slave_mem: ACK_DELAY must be in 0..15");
    end
    if (ADDR_W > IDX_W) begin : g_unused_addr
        logic unused_addr_s;
        assign unused_addr_s = ^addr_i[ADDR_W-1:IDX_W];
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DLY  = 3'd1,
        S_ACK  = 3'd2,
        S_LAT  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               cmd_q, cmd_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               ack_q, ack_d;
    logic               resp_q, resp_d;
    logic               busy_q, busy_d;
    logic               mem_we_s;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    // Next-state, request capture and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    cmd_d   = cmd_i;
                    idx_d   = addr_i[IDX_W-1:0];
                    wdata_d = wdata_i;
                    cnt_d   = 4'd0;
                    state_d = (ACK_DELAY > 0) ? S_DLY : S_ACK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DLY: begin
                if (cnt_q == DLY_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ACK: begin
                cnt_d = 4'd0;
                if (cmd_q) begin
                    state_d = S_IDLE;
                end else if (READ_LATENCY > 1) begin
                    state_d = S_LAT;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_LAT: begin
                if (cnt_q == LAT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The *_d request fields are the live inputs when ACK follows IDLE directly.
        mem_we_s = rst_n_i && (state_d == S_ACK) && cmd_d;
        if ((state_d == S_ACK) && !cmd_d) begin
            hold_d = mem_q[idx_d];
        end else begin
            hold_d = hold_q;
        end
        if (state_d == S_RESP) begin
            rdata_d = hold_q;
        end else begin
            rdata_d = rdata_q;
        end
        ack_d  = (state_d == S_ACK);
        resp_d = (state_d == S_RESP);
        busy_d = (state_d != S_IDLE);
    end

    // Control state, captured request and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            cmd_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            hold_q  <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            resp_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            resp_q  <= resp_d;
            busy_q  <= busy_d;
        end
    end

    // Storage array; deliberately not reset so contents survive rst_n_i.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_q[idx_d] <= wdata_d;
        end
    end

    assign ack_o   = ack_q;
    assign resp_o  = resp_q;
    assign rdata_o = rdata_q;
    assign busy_o  = busy_q;
endmodule
